cache_ctrl: RTL and testbench

//   Sequencer for the set-associative line cache. Accepts one line-read request at a time,

---
 rtl/cache_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_cache_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// -----------------------------------------------------------------------------
// cache_ctrl
//   Sequencer for a set-associative line cache. One line-read request is in
//   flight at a time: the tag lookup result is sampled one cycle after accept.
//   On a hit the cache line is returned. On a miss the line is fetched from
//   memory, written into the cache with a single fill strobe and then returned.
//   Way selection and replacement belong to the cache itself.
//
// Parameters
//   XLEN       address width
//   LINE_SIZE  line size in bytes (line data width is 8*LINE_SIZE)
//   CNT_WIDTH  width of the wrapping hit/miss performance counters
//
// Ports
//   clock, reset                     system clock, synchronous active-high reset
//   req_valid/req_ready/req_addr     line read request (ready only while idle)
//   resp_valid/resp_ready/resp_data  line response, held until accepted
//   cache_write_en/cache_address/
//   cache_data_in                    fill strobe, latched address, fill data
//   cache_data_out/cache_hit         line and tag-match result from the cache
//   mem_req_valid/mem_req_ready/
//   mem_req_addr                     line fetch request (line-aligned address)
//   mem_resp_valid/mem_resp_data     single-beat line data from memory
//   hit_count/miss_count             lookups that hit / missed (wrap to 0)
// -----------------------------------------------------------------------------
module cache_ctrl #(
  parameter int XLEN      = 32,
  parameter int LINE_SIZE = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  // requester side
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [XLEN-1:0]        req_addr,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [8*LINE_SIZE-1:0] resp_data,
  // cache side
  output logic                   cache_write_en,
  output logic [XLEN-1:0]        cache_address,
  output logic [8*LINE_SIZE-1:0] cache_data_in,
  input  logic [8*LINE_SIZE-1:0] cache_data_out,
  input  logic                   cache_hit,
  // memory side
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [XLEN-1:0]        mem_req_addr,
  input  logic                   mem_resp_valid,
  input  logic [8*LINE_SIZE-1:0] mem_resp_data,
  // performance counters
  output logic [CNT_WIDTH-1:0]   hit_count,
  output logic [CNT_WIDTH-1:0]   miss_count
);

  localparam int NOFFSET = $clog2(LINE_SIZE);
  localparam int LW      = 8 * LINE_SIZE;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    READ,
    MISS_REQ,
    MISS_WAIT,
    FILL,
    RESP
  } state_e;

  state_e               state_q;
  logic                 req_ready_q;
  logic                 resp_valid_q;
  logic                 cache_write_en_q;
  logic                 mem_req_valid_q;
  logic [LW-1:0]        resp_data_q;
  logic [LW-1:0]        cache_data_in_q;
  logic [XLEN-1:0]      cache_address_q;
  logic [CNT_WIDTH-1:0] hit_count_q;
  logic [CNT_WIDTH-1:0] miss_count_q;
  logic [CNT_WIDTH-1:0] hit_count_d;
  logic [CNT_WIDTH-1:0] miss_count_d;

  // Plain modular increment: all-ones rolls over to zero.
  assign hit_count_d  = hit_count_q + CNT_WIDTH'(1);
  assign miss_count_d = miss_count_q + CNT_WIDTH'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the line-wide data registers are ordinary flops, not a RAM, so
      // they are cleared with everything else and resp_data reads 0 after reset.
      state_q          <= IDLE;
      req_ready_q      <= 1'b1;
      resp_valid_q     <= 1'b0;
      cache_write_en_q <= 1'b0;
      mem_req_valid_q  <= 1'b0;
      resp_data_q      <= '0;
      cache_data_in_q  <= '0;
      cache_address_q  <= '0;
      hit_count_q      <= '0;
      miss_count_q     <= '0;
    end else begin
      // NOTE: every state register uses a non-blocking assignment so all of
      // them update together from values sampled at the same clock edge.
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            cache_address_q <= req_addr;
            req_ready_q     <= 1'b0;
            state_q         <= LOOKUP;
          end
        end

        // The tag RAM has had a full cycle to settle on cache_address.
        LOOKUP: begin
          if (cache_hit) begin
            hit_count_q <= hit_count_d;
            state_q     <= READ;
          end else begin
            miss_count_q    <= miss_count_d;
            mem_req_valid_q <= 1'b1;
            state_q         <= MISS_REQ;
          end
        end

        READ: begin
          resp_data_q  <= cache_data_out;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end

        // mem_req_addr is derived from cache_address, which is frozen here,
        // so the request stays stable however long memory stalls.
        MISS_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= MISS_WAIT;
          end
        end

        MISS_WAIT: begin
          if (mem_resp_valid) begin
            resp_data_q      <= mem_resp_data;
            cache_data_in_q  <= mem_resp_data;
            cache_write_en_q <= 1'b1;
            state_q          <= FILL;
          end
        end

        // Write strobe was raised on entry; drop it after exactly one cycle.
        FILL: begin
          cache_write_en_q <= 1'b0;
          resp_valid_q     <= 1'b1;
          state_q          <= RESP;
        end

        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_data      = resp_data_q;
  assign cache_write_en = cache_write_en_q;
  assign cache_address  = cache_address_q;
  assign cache_data_in  = cache_data_in_q;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_addr   = {cache_address_q[XLEN-1:NOFFSET], {NOFFSET{1'b0}}};
  assign hit_count      = hit_count_q;
  assign miss_count     = miss_count_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl
//   Drives cache_ctrl with a table of line requests against a small behavioural
//   cache and a memory responder with configurable ready/response latency.
//   Expected line data comes from a fixed address-to-data function and is queued
//   when a request is issued, then popped when the response handshake occurs.
//   Hand-written sequences cover reset during a memory fetch and counter wrap.
//   Built with CNT_WIDTH=4 so the wrap is reachable with 16 hits.
// -----------------------------------------------------------------------------
module tb_cache_ctrl;

  localparam int XLEN      = 32;
  localparam int LINE_SIZE = 64;
  localparam int CNT_WIDTH = 4;
  localparam int NOFF      = 6;
  localparam int LW        = 8 * LINE_SIZE;
  localparam int TW        = XLEN - NOFF;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 req_valid, req_ready;
  logic [XLEN-1:0]      req_addr;
  logic                 resp_valid, resp_ready;
  logic [LW-1:0]        resp_data;
  logic                 cache_write_en;
  logic [XLEN-1:0]      cache_address;
  logic [LW-1:0]        cache_data_in, cache_data_out;
  logic                 cache_hit;
  logic                 mem_req_valid, mem_req_ready;
  logic [XLEN-1:0]      mem_req_addr;
  logic                 mem_resp_valid;
  logic [LW-1:0]        mem_resp_data;
  logic [CNT_WIDTH-1:0] hit_count, miss_count;

  always #5 clock = ~clock;

  cache_ctrl #(
    .XLEN     (XLEN),
    .LINE_SIZE(LINE_SIZE),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .cache_write_en(cache_write_en),
    .cache_address (cache_address),
    .cache_data_in (cache_data_in),
    .cache_data_out(cache_data_out),
    .cache_hit     (cache_hit),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory contents: a distinct pattern per line, derived from the line address.
  function automatic logic [LW-1:0] mem_line(input logic [XLEN-1:0] a);
    logic [LW-1:0]   l;
    logic [XLEN-1:0] base;
    base = {a[XLEN-1:NOFF], {NOFF{1'b0}}};
    for (int k = 0; k < LW / 32; k++)
      l[k*32 +: 32] = base ^ (32'h9E37_79B9 * 32'(k)) ^ 32'h0000_5A00;
    return l;
  endfunction

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ------------------------------------------------------------ cache model
  // Small fully associative store; lookups settle on the falling edge.
  logic [LW-1:0] cm_data [8];
  logic [TW-1:0] cm_tag  [8];
  logic [7:0]    cm_vld = '0;
  int            cm_ptr = 0;

  function automatic int cm_find(input logic [TW-1:0] t);
    for (int i = 0; i < 8; i++)
      if (cm_vld[i] && cm_tag[i] == t) return i;
    return -1;
  endfunction

  always @(posedge clock) begin
    if (cache_write_en) begin
      if (cm_find(cache_address[XLEN-1:NOFF]) < 0) begin
        cm_tag[cm_ptr[2:0]]  <= cache_address[XLEN-1:NOFF];
        cm_data[cm_ptr[2:0]] <= cache_data_in;
        cm_vld[cm_ptr[2:0]]  <= 1'b1;
        cm_ptr               <= cm_ptr + 1;
      end else begin
        cm_data[cm_find(cache_address[XLEN-1:NOFF])] <= cache_data_in;
      end
    end
  end

  initial begin
    cache_hit      = 1'b0;
    cache_data_out = '1;
    forever begin
      int s;
      @(negedge clock);
      s = cm_find(cache_address[XLEN-1:NOFF]);
      cache_hit      = (s >= 0);
      cache_data_out = (s >= 0) ? cm_data[s[2:0]] : {LW{1'b1}};
    end
  end

  // -------------------------------------------------------- memory responder
  int              mem_ready_lat = 0;
  int              mem_resp_lat  = 0;
  bit              mem_auto      = 1'b1;
  bit              mem_pending   = 1'b0;
  int              mem_wait      = 0;
  int              mem_cnt       = 0;
  logic [XLEN-1:0] mem_pend_addr = '0;

  initial begin
    forever begin
      @(posedge clock);
      if (mem_auto) begin
        if (reset) begin
          mem_pending = 1'b0;
          mem_wait    = 0;
        end else begin
          if (mem_resp_valid) mem_pending = 1'b0;
          if (mem_req_valid && mem_req_ready) begin
            mem_pending   = 1'b1;
            mem_cnt       = mem_resp_lat;
            mem_pend_addr = mem_req_addr;
            mem_wait      = 0;
          end else if (mem_req_valid) begin
            mem_wait++;
          end else begin
            mem_wait = 0;
          end
        end
        #1;
        mem_req_ready = mem_req_valid && !mem_pending && (mem_wait >= mem_ready_lat);
        if (mem_pending && mem_cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_line(mem_pend_addr);
        end else begin
          if (mem_pending) mem_cnt--;
          mem_resp_valid = 1'b0;
        end
      end
    end
  end

  // ------------------------------------------------- monitor and scoreboard
  logic [LW-1:0]   sb_q [$];
  int              wr_pulses, wr_bad, mreq_cycles, mreq_hs, mreq_unstable;
  int              resp_unstable, rr_bad, caddr_bad;
  logic [XLEN-1:0] mreq_hs_addr;
  logic            p_reset = 1'b1, p_we = 1'b0, p_mv = 1'b0, p_mr = 1'b0;
  logic            p_rv = 1'b0, p_rr = 1'b0, p_accept = 1'b0;
  logic [XLEN-1:0] p_maddr = '0, p_caddr = '0;
  logic [LW-1:0]   p_rdata = '0;

  task automatic clear_mon();
    wr_pulses = 0; wr_bad = 0; mreq_cycles = 0; mreq_hs = 0; mreq_unstable = 0;
    resp_unstable = 0; rr_bad = 0; caddr_bad = 0; mreq_hs_addr = '0;
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clock);
      if (!reset && !p_reset) begin
        if (cache_write_en) wr_pulses++;
        if (cache_write_en && p_we) wr_bad++;
        if (mem_req_valid) mreq_cycles++;
        if (mem_req_valid && mem_req_ready) begin
          mreq_hs++;
          mreq_hs_addr = mem_req_addr;
        end
        if (p_mv && !p_mr && (!mem_req_valid || mem_req_addr != p_maddr)) mreq_unstable++;
        if (p_rv && !p_rr && (!resp_valid || resp_data != p_rdata)) resp_unstable++;
        if (resp_valid && req_ready) rr_bad++;
        if (cache_address != p_caddr && !p_accept) caddr_bad++;
        if (resp_valid && resp_ready) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected_resp: got data %0h with nothing expected", resp_data);
          end else begin
            check("sb_resp_data", resp_data, sb_q.pop_front());
          end
        end
      end
      p_reset  = reset;
      p_we     = cache_write_en;
      p_mv     = mem_req_valid;
      p_mr     = mem_req_ready;
      p_maddr  = mem_req_addr;
      p_rv     = resp_valid;
      p_rr     = resp_ready;
      p_rdata  = resp_data;
      p_caddr  = cache_address;
      p_accept = req_valid && req_ready;
    end
  end

  // -------------------------------------------------------------- sequences
  int exp_hits   = 0;
  int exp_misses = 0;

  task automatic run_txn(input string tag, input logic [XLEN-1:0] addr,
                         input int rlat, input int mlat, input int stall, input bit exp_hit);
    int              e_cyc, r_cyc;
    bit              got;
    logic [XLEN-1:0] line_addr;
    line_addr     = {addr[XLEN-1:NOFF], {NOFF{1'b0}}};
    mem_ready_lat = rlat;
    mem_resp_lat  = mlat;
    clear_mon();
    sb_q.push_back(mem_line(addr));
    if (exp_hit) exp_hits++;
    else         exp_misses++;

    @(posedge clock); #1;
    req_valid  = 1'b1;
    req_addr   = addr;
    resp_ready = (stall == 0);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (req_ready) got = 1'b1;
    end
    check({tag, "_accept"}, got, 1);
    e_cyc = cyc + 1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    req_addr  = $urandom();   // must not leak into cache_address

    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clock);
      if (resp_valid) got = 1'b1;
    end
    r_cyc = cyc;
    check({tag, "_resp_seen"}, got, 1);
    check({tag, "_latency"}, r_cyc - e_cyc, exp_hit ? 2 : 4 + rlat + mlat);

    if (stall > 0) begin
      for (int i = 1; i < stall; i++) @(negedge clock);
      @(posedge clock); #1;
      resp_ready = 1'b1;
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (!resp_valid) got = 1'b1;
    end
    check({tag, "_resp_done"}, got, 1);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_hit_count"}, hit_count, exp_hits[CNT_WIDTH-1:0]);
    check({tag, "_miss_count"}, miss_count, exp_misses[CNT_WIDTH-1:0]);
    check({tag, "_cache_address"}, cache_address, addr);
    check({tag, "_fill_pulses"}, wr_pulses, exp_hit ? 0 : 1);
    check({tag, "_mem_handshakes"}, mreq_hs, exp_hit ? 0 : 1);
    check({tag, "_mem_req_cycles"}, mreq_cycles, exp_hit ? 0 : rlat + 1);
    if (!exp_hit) check({tag, "_mem_req_addr"}, mreq_hs_addr, line_addr);
    check({tag, "_stability"}, mreq_unstable + resp_unstable + wr_bad, 0);
    check({tag, "_ordering"}, rr_bad + caddr_bad, 0);
  endtask

  typedef struct {
    logic [XLEN-1:0] addr;
    int              rlat;
    int              mlat;
    int              stall;
    bit              hit;
  } vec_t;

  vec_t vecs [9];

  initial begin
    bit saw_we, saw_rv, saw_mv, saw_busy, got;

    vecs[0] = '{32'h0000_1040, 0, 2, 0, 1'b0};  // cold miss
    vecs[1] = '{32'h0000_107C, 0, 0, 0, 1'b1};  // same line, different offset
    vecs[2] = '{32'h0000_2000, 5, 1, 0, 1'b0};  // memory holds ready low 5 cycles
    vecs[3] = '{32'h0000_2010, 0, 0, 4, 1'b1};  // requester stalls 4 cycles
    vecs[4] = '{32'h0000_1000, 0, 0, 0, 1'b0};  // neighbouring line, 0-wait memory
    vecs[5] = '{32'h0000_1041, 0, 0, 1, 1'b1};
    vecs[6] = '{32'hFFFF_FFC0, 0, 3, 2, 1'b0};  // top line of address space
    vecs[7] = '{32'hFFFF_FFFF, 1, 0, 0, 1'b1};
    vecs[8] = '{32'h0000_0000, 0, 0, 0, 1'b0};

    reset          = 1'b1;
    req_valid      = 1'b0;
    req_addr       = '0;
    resp_ready     = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_cache_write_en", cache_write_en, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_cache_address", cache_address, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      run_txn($sformatf("v%0d", i), vecs[i].addr, vecs[i].rlat, vecs[i].mlat,
              vecs[i].stall, vecs[i].hit);

    // Reset while waiting for memory data, then present the late data.
    @(posedge clock); #1;
    mem_auto       = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    req_valid      = 1'b1;
    req_addr       = 32'h0000_3000;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (req_ready) got = 1'b1;
    end
    check("abort_accept", got, 1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clock);
      if (mem_req_valid) got = 1'b1;
    end
    check("abort_mem_req", got, 1);
    mem_req_ready = 1'b1;
    @(posedge clock); #1;
    mem_req_ready = 1'b0;
    @(negedge clock);
    check("abort_in_miss_wait", mem_req_valid, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset          = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = mem_line(32'h0000_3000);
    saw_we = 1'b0; saw_rv = 1'b0; saw_mv = 1'b0; saw_busy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (cache_write_en) saw_we = 1'b1;
      if (resp_valid)     saw_rv = 1'b1;
      if (mem_req_valid)  saw_mv = 1'b1;
      if (!req_ready)     saw_busy = 1'b1;
      if (i == 2) mem_resp_valid = 1'b0;
    end
    check("abort_no_fill", saw_we, 0);
    check("abort_no_resp", saw_rv, 0);
    check("abort_no_mem_req", saw_mv, 0);
    check("abort_idle", saw_busy, 0);
    check("abort_hit_count", hit_count, 0);
    check("abort_miss_count", miss_count, 0);
    check("abort_cache_address", cache_address, 0);
    exp_hits   = 0;
    exp_misses = 0;
    @(posedge clock); #1;
    mem_auto = 1'b1;

    // The aborted line was never filled, so it misses again.
    run_txn("post_abort", 32'h0000_3000, 0, 1, 0, 1'b0);

    // 15 hits reach all-ones; the 16th wraps to zero.
    for (int i = 0; i < 16; i++)
      run_txn($sformatf("wrap%0d", i), 32'h0000_3000 + 32'(i), 0, 0, 0, 1'b1);
    check("wrap_hit_count_zero", hit_count, 0);
    check("wrap_miss_count", miss_count, 1);

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

endmodule
